// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, latches memory words into the IR,
// handles stall/jump/HALT and an optional return-address stack (FETCH_RAS_EN).
module fetch_unit #(
   parameter int                          PC_WIDTH          = 5,
   parameter int                          INSTRUCTION_WIDTH = 40,
   parameter int                          OPCODE_WIDTH      = 8,
   parameter logic [OPCODE_WIDTH-1:0]     HALT_OPCODE       = 8'hFF,
   parameter logic [PC_WIDTH-1:0]         RESET_PC          = '0,
   parameter int                          RAS_DEPTH         = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   output logic [PC_WIDTH-1:0]          pc_o,
   input  logic [INSTRUCTION_WIDTH-1:0] instruction_i,
   input  logic                         stall_i,
   input  logic                         jump_i,
   input  logic [PC_WIDTH-1:0]          jump_target_i,
   input  logic                         call_i,
   input  logic                         ret_i,
   input  logic                         resume_i,
   output logic [INSTRUCTION_WIDTH-1:0] ir_o,
   output logic [PC_WIDTH-1:0]          ir_pc_o,
   output logic                         ir_valid_o,
   output logic                         halted_o,
   output logic                         ras_err_o
);

   typedef enum logic [1:0] {
      S_FILL,
      S_RUN,
      S_HALT
   } state_t;

   state_t                         r_state, w_state_nxt;
   logic [PC_WIDTH-1:0]            r_pc, w_pc_nxt;
   logic [INSTRUCTION_WIDTH-1:0]   r_ir, w_ir_nxt;
   logic [PC_WIDTH-1:0]            r_ir_pc, w_ir_pc_nxt;
   logic                           r_valid, w_valid_nxt;
   logic                           r_halted, w_halted_nxt;
   logic                           r_ras_err;

   logic                           w_run;
   logic                           w_redirect;
   logic [PC_WIDTH-1:0]            w_target;
   logic                           w_ras_err;
   logic [OPCODE_WIDTH-1:0]        w_opcode;
   logic                           w_is_halt;

   assign w_run     = (r_state != S_HALT);
   assign w_opcode  = instruction_i[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH];
   assign w_is_halt = (w_opcode == HALT_OPCODE);

`ifdef FETCH_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [PC_WIDTH-1:0] r_ras [RAS_DEPTH];
   logic [PW-1:0]       r_ras_ptr;
   logic [CW-1:0]       r_ras_cnt;
   logic [PW-1:0]       w_ptr_inc, w_ptr_dec;
   logic                w_full, w_empty;
   logic                w_push, w_pop;

   // Pointer marks the next free slot; wraps so a full push hits the oldest.
   assign w_ptr_inc = (r_ras_ptr == PW'(RAS_DEPTH - 1)) ? '0 : r_ras_ptr + 1'b1;
   assign w_ptr_dec = (r_ras_ptr == '0) ? PW'(RAS_DEPTH - 1) : r_ras_ptr - 1'b1;
   assign w_full    = (r_ras_cnt == CW'(RAS_DEPTH));
   assign w_empty   = (r_ras_cnt == '0);

   always_comb begin
      w_redirect = 1'b0;
      w_target   = jump_target_i;
      w_push     = 1'b0;
      w_pop      = 1'b0;
      w_ras_err  = 1'b0;
      if (w_run) begin
         if (call_i) begin
            w_redirect = 1'b1;
            w_push     = 1'b1;
            w_ras_err  = w_full;
         end else if (ret_i) begin
            w_redirect = 1'b1;
            w_pop      = ~w_empty;
            w_ras_err  = w_empty;
            w_target   = w_empty ? RESET_PC : r_ras[w_ptr_dec];
         end else if (jump_i) begin
            w_redirect = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ras_ptr <= '0;
         r_ras_cnt <= '0;
         for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
      end else if (w_push) begin
         r_ras[r_ras_ptr] <= r_ir_pc + 1'b1;
         r_ras_ptr        <= w_ptr_inc;
         if (!w_full) r_ras_cnt <= r_ras_cnt + 1'b1;
      end else if (w_pop) begin
         r_ras_ptr <= w_ptr_dec;
         r_ras_cnt <= r_ras_cnt - 1'b1;
      end
   end
`else
   logic w_unused;

   assign w_unused   = ^{call_i, ret_i};
   assign w_redirect = w_run & jump_i;
   assign w_target   = jump_target_i;
   assign w_ras_err  = 1'b0;
`endif

   always_comb begin
      w_state_nxt  = r_state;
      w_pc_nxt     = r_pc;
      w_ir_nxt     = r_ir;
      w_ir_pc_nxt  = r_ir_pc;
      w_valid_nxt  = r_valid;
      w_halted_nxt = r_halted;
      case (r_state)
         S_FILL, S_RUN: begin
            w_state_nxt = S_RUN;
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_valid_nxt = 1'b0;
            end else if (!stall_i) begin
               w_ir_nxt    = instruction_i;
               w_ir_pc_nxt = r_pc;
               w_valid_nxt = 1'b1;
               if (w_is_halt) begin
                  w_state_nxt  = S_HALT;
                  w_halted_nxt = 1'b1;
               end else begin
                  w_pc_nxt = r_pc + 1'b1;
               end
            end
         end
         S_HALT: begin
            w_valid_nxt = 1'b0;
            if (resume_i) begin
               w_pc_nxt     = r_pc + 1'b1;
               w_halted_nxt = 1'b0;
               w_state_nxt  = S_RUN;
            end
         end
         default: w_state_nxt = S_FILL;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_FILL;
         r_pc      <= RESET_PC;
         r_ir      <= '0;
         r_ir_pc   <= '0;
         r_valid   <= 1'b0;
         r_halted  <= 1'b0;
         r_ras_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_pc      <= w_pc_nxt;
         r_ir      <= w_ir_nxt;
         r_ir_pc   <= w_ir_pc_nxt;
         r_valid   <= w_valid_nxt;
         r_halted  <= w_halted_nxt;
         r_ras_err <= w_ras_err;
      end
   end

   assign pc_o       = r_pc;
   assign ir_o       = r_ir;
   assign ir_pc_o    = r_ir_pc;
   assign ir_valid_o = r_valid;
   assign halted_o   = r_halted;
   assign ras_err_o  = r_ras_err;

endmodule
